// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
// Holds the FSM state encoding and the default sizing constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } tx_state_e;

    localparam int DEF_N_REQ       = 4;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_TIMEOUT_CYC = 60000;

    // Index width that stays legal even for a single-entry table.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester/engine bundle for uart_tx_scheduler.
// master = requesters plus transmit engine, slave = the scheduler.
interface uart_tx_scheduler_if #(
    parameter int N_REQ  = uart_pkg::DEF_N_REQ,
    parameter int DATA_W = uart_pkg::DEF_DATA_W
);
    import uart_pkg::*;

    localparam int IDX_W = idx_w(N_REQ);

    logic [N_REQ-1:0]             req;
    logic [N_REQ-1:0][DATA_W-1:0] req_data;
    logic [N_REQ-1:0]             ack;
    logic [DATA_W-1:0]            tx_data;
    logic                         tx_start;
    logic                         tx_done;
    logic [IDX_W-1:0]             grant_id;
    logic                         busy;
    logic                         err_timeout;

    modport master (
        output req, req_data, tx_done,
        input  ack, tx_data, tx_start, grant_id, busy, err_timeout
    );

    modport slave (
        input  req, req_data, tx_done,
        output ack, tx_data, tx_start, grant_id, busy, err_timeout
    );

endinterface

// File: rtl/uart_rr_arbiter.sv
// Combinational rotating-priority select: the first requester at or after
// ptr wins, wrapping to the lowest index when nothing sits above ptr.
module uart_rr_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [N_REQ-1:0] hi_mask;
    logic [N_REQ-1:0] req_hi;
    logic [N_REQ-1:0] pick_src;

    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            hi_mask[i] = (i >= int'(ptr));
        end
        req_hi   = req & hi_mask;
        pick_src = (|req_hi) ? req_hi : req;
        // Isolate the lowest set bit of the chosen half.
        gnt      = pick_src & (~pick_src + 1'b1);
        gnt_idx  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (gnt[i]) gnt_idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmit engine among N_REQ byte producers, one byte per
// grant, with a watchdog that abandons frames the engine never completes.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int N_REQ       = DEF_N_REQ,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_scheduler_if.slave bus
);

    localparam int               IDX_W    = idx_w(N_REQ);
    localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    tx_state_e         state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  ptr_inc;
    logic [IDX_W-1:0]  win_idx;
    logic [N_REQ-1:0]  win_oh;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              start_q, start_d;
    logic              err_q, err_d;
    logic              busy_q;
    logic              any_req;

    uart_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req     (bus.req),
        .ptr     (ptr_q),
        .gnt     (win_oh),
        .gnt_idx (win_idx)
    );

    assign any_req = |bus.req;
    // Next round starts just past whoever was served, whether it finished or timed out.
    assign ptr_inc = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        start_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = START;
                    grant_d = win_idx;
                    data_d  = bus.req_data[win_idx];
                    ack_d   = win_oh;
                    start_d = 1'b1;
                end
            end
            START: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A completion on the last allowed cycle still counts as success.
                if (bus.tx_done || cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    ptr_d   = ptr_inc;
                    err_d   = ~bus.tx_done;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            start_q <= start_d;
            err_q   <= err_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign bus.ack         = ack_q;
    assign bus.tx_data     = data_q;
    assign bus.tx_start    = start_q;
    assign bus.grant_id    = grant_q;
    assign bus.busy        = busy_q;
    assign bus.err_timeout = err_q;

endmodule
